// File: rtl/ac_table_writer_if.sv
// Symbol stream plus goto/output RAM write-side bundle for the Aho-Corasick table writer.
// master = writer side, slave = symbol source / RAM side.
interface ac_table_writer_if #(
  parameter int SW  = 4,
  parameter int STW = 8,
  parameter int AW  = SW + STW
);
  logic           SYM_VALID;
  logic           SYM_READY;
  logic [SW-1:0]  SYM;
  logic           SYM_LAST;
  logic [AW-1:0]  RD_ADDR;
  logic [STW-1:0] RD_DATA;
  logic           WR_EN;
  logic [AW-1:0]  WR_ADDR;
  logic [STW-1:0] WR_DATA;
  logic           OUT_WE;
  logic [STW-1:0] OUT_ADDR;
  logic [7:0]     OUT_DATA;

  modport master (
    input  SYM_VALID, SYM, SYM_LAST, RD_DATA,
    output SYM_READY, RD_ADDR, WR_EN, WR_ADDR, WR_DATA, OUT_WE, OUT_ADDR, OUT_DATA
  );

  modport slave (
    output SYM_VALID, SYM, SYM_LAST, RD_DATA,
    input  SYM_READY, RD_ADDR, WR_EN, WR_ADDR, WR_DATA, OUT_WE, OUT_ADDR, OUT_DATA
  );
endinterface

// File: rtl/ac_table_writer.sv
// Aho-Corasick goto/output table builder: clears both RAMs, then walks the trie per
// symbol, allocating states on a miss and tagging the end state of each pattern.
module ac_table_writer #(
  parameter int SW         = 4,
  parameter int STW        = 8,
  parameter int AW         = SW + STW,
  parameter int MAX_STATES = 256
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  ac_table_writer_if.master   bus,
  output logic [STW:0]        STATE_COUNT,
  output logic                BUSY,
  output logic                OVERFLOW
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_READY,
    ST_LOOKUP,
    ST_EVAL,
    ST_MARK,
    ST_ERROR
  } state_e;

  state_e         state_q;
  logic [AW-1:0]  clr_q;
  logic [STW-1:0] cur_q;
  logic [STW:0]   free_q;
  logic [7:0]     pid_q;
  logic [SW-1:0]  sym_q;
  logic           last_q;
  logic           ovf_q;

  logic hit;
  logic room;

  assign hit  = (bus.RD_DATA != '0);
  assign room = (free_q < (STW+1)'(MAX_STATES));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      clr_q   <= '0;
      cur_q   <= '0;
      free_q  <= '0;
      pid_q   <= '0;
      sym_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
          end
        end
        ST_CLEAR: begin
          clr_q <= clr_q + AW'(1);
          if (clr_q == '1) begin
            cur_q   <= '0;
            free_q  <= (STW+1)'(1);
            pid_q   <= 8'd1;
            ovf_q   <= 1'b0;
            state_q <= ST_READY;
          end
        end
        ST_READY: begin
          if (START) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
          end else if (bus.SYM_VALID) begin
            sym_q   <= bus.SYM;
            last_q  <= bus.SYM_LAST;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state_q <= ST_EVAL;
        ST_EVAL: begin
          if (hit) begin
            cur_q   <= bus.RD_DATA;
            state_q <= last_q ? ST_MARK : ST_READY;
          end else if (room) begin
            cur_q   <= free_q[STW-1:0];
            free_q  <= free_q + (STW+1)'(1);
            state_q <= last_q ? ST_MARK : ST_READY;
          end else begin
            ovf_q   <= 1'b1;
            state_q <= ST_ERROR;
          end
        end
        ST_MARK: begin
          // pid_q wraps to 0 after id 255 has been handed out
          if (pid_q == '0) begin
            ovf_q   <= 1'b1;
            state_q <= ST_ERROR;
          end else begin
            pid_q   <= pid_q + 8'd1;
            cur_q   <= '0;
            state_q <= ST_READY;
          end
        end
        ST_ERROR: begin
          if (START) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM-side ports are decoded from the state register; the EVAL write depends on
  // the same-cycle RD_DATA, and the READY read address on the live SYM.
  always_comb begin
    bus.SYM_READY = (state_q == ST_READY);
    bus.RD_ADDR   = '0;
    bus.WR_EN     = 1'b0;
    bus.WR_ADDR   = '0;
    bus.WR_DATA   = '0;
    bus.OUT_WE    = 1'b0;
    bus.OUT_ADDR  = '0;
    bus.OUT_DATA  = '0;
    case (state_q)
      ST_CLEAR: begin
        bus.WR_EN    = 1'b1;
        bus.WR_ADDR  = clr_q;
        bus.OUT_WE   = (clr_q[AW-1:STW] == '0);
        bus.OUT_ADDR = clr_q[STW-1:0];
      end
      ST_READY:  bus.RD_ADDR = {cur_q, bus.SYM};
      ST_LOOKUP: bus.RD_ADDR = {cur_q, sym_q};
      ST_EVAL: begin
        bus.RD_ADDR = {cur_q, sym_q};
        if (!hit && room) begin
          bus.WR_EN   = 1'b1;
          bus.WR_ADDR = {cur_q, sym_q};
          bus.WR_DATA = free_q[STW-1:0];
        end
      end
      ST_MARK: begin
        if (pid_q != '0) begin
          bus.OUT_WE   = 1'b1;
          bus.OUT_ADDR = cur_q;
          bus.OUT_DATA = pid_q;
        end
      end
      default: ;
    endcase
  end

  assign BUSY        = (state_q == ST_CLEAR) || (state_q == ST_LOOKUP) ||
                       (state_q == ST_EVAL)  || (state_q == ST_MARK);
  assign OVERFLOW    = ovf_q;
  assign STATE_COUNT = free_q;

endmodule

// File: tb/tb_ac_table_writer.sv
// Self-checking bench for ac_table_writer: RAM model, write scoreboard and a trie reference model.
module tb_ac_table_writer;
  localparam int SW  = 4;
  localparam int STW = 8;
  localparam int AW  = 12;

  logic           CLK = 1'b0;
  logic           RST;
  logic           START;
  logic [STW:0]   STATE_COUNT;
  logic           BUSY;
  logic           OVERFLOW;

  ac_table_writer_if #(.SW(SW), .STW(STW), .AW(AW)) bus ();

  ac_table_writer #(.SW(SW), .STW(STW), .AW(AW), .MAX_STATES(256)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .bus        (bus),
    .STATE_COUNT(STATE_COUNT),
    .BUSY       (BUSY),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // goto RAM model, preloaded with junk so the clear pass matters
  logic [STW-1:0] gmem [0:4095];
  initial for (int i = 0; i < 4096; i++) gmem[i] <= 8'h5A;
  always @(posedge CLK) begin
    if (bus.WR_EN) gmem[bus.WR_ADDR] <= bus.WR_DATA;
    bus.RD_DATA <= gmem[bus.RD_ADDR];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t gq[$];
  wr_t oq[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  bit  clearing = 1'b0;
  int  clr_w, clr_o, clr_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    wr_t e;
    if (clearing) begin
      if (bus.WR_EN) begin
        if (bus.WR_ADDR != AW'(clr_w) || bus.WR_DATA != '0) clr_bad++;
        clr_w++;
      end
      if (bus.OUT_WE) begin
        if (bus.OUT_ADDR != STW'(clr_o) || bus.OUT_DATA != '0) clr_bad++;
        clr_o++;
      end
    end else begin
      if (bus.WR_EN) begin
        if (gq.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL goto_wr unexpected: got addr %0h data %0h expected none", bus.WR_ADDR, bus.WR_DATA);
        end else begin
          e = gq.pop_front();
          chk("goto_wr", {bus.WR_ADDR, bus.WR_DATA}, {e.addr, e.data});
        end
      end
      if (bus.OUT_WE) begin
        if (oq.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL out_wr unexpected: got addr %0h data %0h expected none", bus.OUT_ADDR, bus.OUT_DATA);
        end else begin
          e = oq.pop_front();
          chk("out_wr", {4'h0, bus.OUT_ADDR, bus.OUT_DATA}, {e.addr, e.data});
        end
      end
    end
  end

  // Reference trie
  int m_goto [int];
  int m_cur, m_free, m_pid;
  bit m_err;

  task automatic model_reset();
    m_goto.delete();
    m_cur = 0; m_free = 1; m_pid = 1; m_err = 1'b0;
  endtask

  task automatic model_step(input int sym, input bit last, input bit push);
    int key;
    key = m_cur * 16 + sym;
    if (m_goto.exists(key)) m_cur = m_goto[key];
    else if (m_free < 256) begin
      if (push) gq.push_back(wr_t'{AW'(key), 8'(m_free)});
      m_goto[key] = m_free;
      m_cur = m_free;
      m_free++;
    end else begin
      m_err = 1'b1;
      return;
    end
    if (last) begin
      if (m_pid == 0) begin
        m_err = 1'b1;
        return;
      end
      if (push) oq.push_back(wr_t'{AW'(m_cur), 8'(m_pid)});
      m_pid = (m_pid + 1) % 256;
      m_cur = 0;
    end
  endtask

  task automatic send_sym(input int sym, input bit last, input bit push);
    for (int i = 0; i < 10 && !bus.SYM_READY; i++) @(negedge CLK);
    if (!bus.SYM_READY) begin
      n_assert++; n_fail++;
      $display("FAIL handshake timeout: got SYM_READY 0 expected 1");
      return;
    end
    bus.SYM_VALID = 1'b1;
    bus.SYM       = SW'(sym);
    bus.SYM_LAST  = last;
    model_step(sym, last, push);
    @(negedge CLK);
    bus.SYM_VALID = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 8 && !bus.SYM_READY; i++) @(negedge CLK);
    chk("ready after symbol", bus.SYM_READY, !m_err);
    chk("goto queue drained", gq.size(), 0);
    chk("out queue drained", oq.size(), 0);
  endtask

  task automatic do_clear(input bit with_valid);
    int n;
    START = 1'b1;
    if (with_valid) begin
      bus.SYM_VALID = 1'b1; bus.SYM = 4'h3; bus.SYM_LAST = 1'b0;
    end
    clr_w = 0; clr_o = 0; clr_bad = 0;
    clearing = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 1;
    chk("busy in clear", BUSY, 1);
    while (!bus.SYM_READY && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    bus.SYM_VALID = 1'b0;
    clearing = 1'b0;
    chk("clear cycles to ready", n, 4097);
    chk("clear goto writes", clr_w, 4096);
    chk("clear out writes", clr_o, 256);
    chk("clear bad writes", clr_bad, 0);
    chk("state count after clear", STATE_COUNT, 1);
    chk("overflow after clear", OVERFLOW, 0);
    chk("busy after clear", BUSY, 0);
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " SYM_READY"}, bus.SYM_READY, 0);
    chk({tag, " WR_EN"}, bus.WR_EN, 0);
    chk({tag, " OUT_WE"}, bus.OUT_WE, 0);
    chk({tag, " BUSY"}, BUSY, 0);
    chk({tag, " OVERFLOW"}, OVERFLOW, 0);
    chk({tag, " RD_ADDR"}, bus.RD_ADDR, 0);
    chk({tag, " WR_ADDR"}, bus.WR_ADDR, 0);
    chk({tag, " OUT_ADDR"}, bus.OUT_ADDR, 0);
    chk({tag, " STATE_COUNT"}, STATE_COUNT, 0);
  endtask

  typedef struct {
    int sym; bit last;
    bit gw; int gaddr; int gdata;
    bit ow; int oaddr; int odata;
    int cnt;
  } vec_t;

  vec_t vt [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vt[0]  = '{3, 1'b0, 1'b1, 'h003, 1, 1'b0, 0, 0, 2};
    vt[1]  = '{5, 1'b0, 1'b1, 'h015, 2, 1'b0, 0, 0, 3};
    vt[2]  = '{7, 1'b1, 1'b1, 'h027, 3, 1'b1, 3, 1, 4};
    vt[3]  = '{3, 1'b0, 1'b0, 0,     0, 1'b0, 0, 0, 4};
    vt[4]  = '{5, 1'b0, 1'b0, 0,     0, 1'b0, 0, 0, 4};
    vt[5]  = '{9, 1'b1, 1'b1, 'h029, 4, 1'b1, 4, 2, 5};
    vt[6]  = '{3, 1'b0, 1'b0, 0,     0, 1'b0, 0, 0, 5};
    vt[7]  = '{5, 1'b1, 1'b0, 0,     0, 1'b1, 2, 3, 5};
    vt[8]  = '{3, 1'b0, 1'b0, 0,     0, 1'b0, 0, 0, 5};
    vt[9]  = '{5, 1'b0, 1'b0, 0,     0, 1'b0, 0, 0, 5};
    vt[10] = '{7, 1'b1, 1'b0, 0,     0, 1'b1, 3, 4, 5};

    RST = 1'b1; START = 1'b0;
    bus.SYM_VALID = 1'b0; bus.SYM = '0; bus.SYM_LAST = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    @(negedge CLK);

    // IDLE ignores symbols
    bus.SYM_VALID = 1'b1; bus.SYM = 4'h3;
    repeat (3) @(negedge CLK);
    chk("idle SYM_READY", bus.SYM_READY, 0);
    chk("idle BUSY", BUSY, 0);
    bus.SYM_VALID = 1'b0;

    do_clear(1'b0);

    foreach (vt[v]) begin
      if (vt[v].gw) gq.push_back(wr_t'{AW'(vt[v].gaddr), 8'(vt[v].gdata)});
      if (vt[v].ow) oq.push_back(wr_t'{AW'(vt[v].oaddr), 8'(vt[v].odata)});
      send_sym(vt[v].sym, vt[v].last, 1'b0);
      settle();
      chk("STATE_COUNT vector", STATE_COUNT, vt[v].cnt);
    end

    // SYM_VALID held through LOOKUP/EVAL: exactly two symbols consumed
    bus.SYM_VALID = 1'b1; bus.SYM = 4'h3; bus.SYM_LAST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30 && cnt < 2; i++) begin
      if (bus.SYM_READY) begin
        model_step(3, 1'b0, 1'b1);
        cnt++;
      end
      @(negedge CLK);
    end
    bus.SYM_VALID = 1'b0;
    chk("held valid consumptions", cnt, 2);
    settle();
    send_sym(4, 1'b1, 1'b1);
    settle();
    chk("STATE_COUNT after hold", STATE_COUNT, m_free);

    // START during LOOKUP is ignored
    send_sym(7, 1'b1, 1'b1);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    settle();
    chk("STATE_COUNT after ignored START", STATE_COUNT, m_free);

    // START beats SYM_VALID in READY
    do_clear(1'b1);

    // Fill the state space, then one more new edge
    for (int k = 0; k < 255; k++) begin
      send_sym(k % 16, k == 254, 1'b1);
      settle();
    end
    chk("STATE_COUNT full", STATE_COUNT, 256);
    send_sym(1, 1'b0, 1'b1);
    settle();
    chk("overflow on state exhaustion", OVERFLOW, 1);
    chk("error BUSY", BUSY, 0);
    chk("error SYM_READY", bus.SYM_READY, 0);
    bus.SYM_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    bus.SYM_VALID = 1'b0;
    chk("error holds overflow", OVERFLOW, 1);

    do_clear(1'b0);

    // Pattern id wrap
    for (int p = 0; p < 256; p++) begin
      send_sym(3, 1'b1, 1'b1);
      settle();
    end
    chk("overflow on pattern id wrap", OVERFLOW, 1);
    chk("pid wrap SYM_READY", bus.SYM_READY, 0);
    chk("pid wrap STATE_COUNT", STATE_COUNT, 2);

    do_clear(1'b0);

    // RST during EVAL
    send_sym(6, 1'b0, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_all_zero("rst mid-eval");
    RST = 1'b0;
    bus.SYM_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    bus.SYM_VALID = 1'b0;
    chk("post-rst idle SYM_READY", bus.SYM_READY, 0);
    chk("post-rst goto queue", gq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ac_table_writer.md
Name: ac_table_writer

Overview:
- Builds the Aho-Corasick goto table and output table in RAM from a stream of pattern symbols. It is the writer counterpart of the table reader path.
- It clears both tables, then walks the trie for each incoming 4-bit symbol and allocates new states on a miss. On the last symbol of each pattern it writes a pattern id into the output table.
- It drives the write side of the goto RAM, keyed by {state, symbol}, and of the output RAM. The table readers consume both tables once BUSY is low.

Parameters:
- SW, 4, symbol width in bits (CHARA width).
- STW, 8, state number width.
- AW, SW+STW (12), goto RAM address width.
- MAX_STATES, 256, number of allocatable states including root 0.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- START  input  1  one-cycle pulse: clear tables and begin a new build
- SYM_VALID  input  1  symbol handshake valid
- SYM_READY  output  1  symbol handshake ready
- SYM  input  SW  pattern symbol
- SYM_LAST  input  1  SYM is the final symbol of the current pattern
- RD_ADDR  output  AW  goto RAM read address; RAM is synchronous, data valid the next cycle
- RD_DATA  input  STW  goto RAM read data; 0 means no transition
- WR_EN  output  1  goto RAM write enable
- WR_ADDR  output  AW  goto RAM write address
- WR_DATA  output  STW  goto RAM write data
- OUT_WE  output  1  output-table write enable
- OUT_ADDR  output  STW  output-table address (state)
- OUT_DATA  output  8  pattern id; 0 means no match
- STATE_COUNT  output  STW+1  next free state number (= states in use)
- BUSY  output  1  high in CLEAR, LOOKUP, EVAL, MARK
- OVERFLOW  output  1  sticky: state space or pattern id space exhausted

Behaviour:
Reset:
- RST forces IDLE.
- All outputs read 0 on reset: SYM_READY, WR_EN, OUT_WE, BUSY, OVERFLOW, the addresses and STATE_COUNT.
- Internal cur, next_free and pat_id are cleared to 0.
- RST mid-clear or mid-build abandons the operation; table contents are then undefined until the next START.

FSM states: IDLE, CLEAR, READY, LOOKUP, EVAL, MARK, ERROR.

- IDLE:
  - SYM_READY=0.
  - START -> CLEAR with clear counter 0.
- CLEAR:
  - One goto write per cycle: WR_EN=1, WR_ADDR=counter, WR_DATA=0, for counter 0..2^AW-1 (4096 cycles).
  - During the first 2^STW cycles, also OUT_WE=1, OUT_ADDR=counter[STW-1:0], OUT_DATA=0.
  - After the write to address 4095: cur<=0, next_free<=1, pat_id<=1, OVERFLOW<=0, then -> READY.
- READY:
  - SYM_READY=1.
  - On SYM_VALID&SYM_READY: capture SYM and SYM_LAST, drive RD_ADDR={cur,SYM} in the same cycle, -> LOOKUP.
  - START in READY restarts CLEAR.
- LOOKUP: one wait cycle for RAM latency, -> EVAL.
- EVAL:
  - RD_DATA!=0: cur<=RD_DATA, no write.
  - RD_DATA==0 and next_free<MAX_STATES: WR_EN=1, WR_ADDR={cur,sym}, WR_DATA=next_free; cur<=next_free; next_free<=next_free+1.
  - RD_DATA==0 and next_free==MAX_STATES: OVERFLOW<=1, no write, -> ERROR.
  - Next state is MARK if last was captured, else READY.
- MARK:
  - pat_id==0 (wrapped past 255): OVERFLOW<=1, no write, -> ERROR.
  - Otherwise: OUT_WE=1, OUT_ADDR=cur, OUT_DATA=pat_id; pat_id<=pat_id+1 (8-bit, wraps to 0); cur<=0; -> READY.
- ERROR:
  - SYM_READY=0, BUSY=0, OVERFLOW held.
  - Exited only by START (-> CLEAR) or RST.

Timing and hazards:
- Throughput is 3 cycles per symbol, plus 1 cycle for MARK.
- A goto write issued in EVAL lands at least one cycle before the next read is issued, so there is no read-after-write hazard.
- RD_DATA is never 0 for a real edge, because root 0 is never a target.
- Duplicate pattern: no new states; MARK overwrites the end state with the new id.
- A pattern that is a prefix of an earlier pattern marks an internal state.
- SYM_VALID while SYM_READY=0 is ignored and not consumed.
- START has priority over SYM_VALID in the same cycle.
- START outside IDLE, READY or ERROR is ignored.
- STATE_COUNT = next_free, zero-extended.

Test Plan:
- Reset then START -> exactly 4096 WR_EN pulses with WR_DATA=0 and 256 OUT_WE pulses with OUT_DATA=0; SYM_READY rises on cycle 4097; STATE_COUNT=1.
- Pattern {3,5,7(last)} -> goto writes {0,3}=1, {1,5}=2, {2,7}=3; OUT_WE addr 3 data 1; STATE_COUNT=4.
- Then {3,5,9(last)} -> no writes for 3 and 5; write {2,9}=4; OUT_WE addr 4 data 2; STATE_COUNT=5.
- Then {3,5(last)} (prefix) -> no goto writes; OUT_WE addr 2 data 3.
- Fill to next_free=256, then send a new-edge symbol -> OVERFLOW=1, no WR_EN, SYM_READY=0; START -> CLEAR, OVERFLOW=0.
- Hold SYM_VALID during LOOKUP/EVAL -> each symbol consumed once; RST mid-EVAL -> all outputs 0 next cycle, state IDLE.
